// File: rtl/eab_pipe.sv
// eab_pipe: two-stage effective-address generator for the LC-3b datapath.
// Stage 1 captures the selected base and the sign-extended, optionally
// shifted offset. Stage 2 adds them and flags misaligned word accesses.
// A valid/ready handshake on both sides carries a request tag through the pipe.
module eab_pipe #(
    parameter int unsigned WIDTH       = 16,
    parameter int unsigned OFF_A_W     = 6,
    parameter int unsigned OFF_B_W     = 9,
    parameter int unsigned OFF_C_W     = 11,
    parameter int unsigned TAG_W       = 4,
    parameter bit          ALIGN_CHECK = 1'b1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [OFF_C_W-1:0] ir_slice,
    input  logic [WIDTH-1:0]   r,
    input  logic [WIDTH-1:0]   pc,
    input  logic               addr1_sel,
    input  logic [1:0]         addr2_sel,
    input  logic               lshf1,
    input  logic               word,
    input  logic [TAG_W-1:0]   in_tag,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   out_ea,
    output logic               out_misalign,
    output logic [TAG_W-1:0]   out_tag
);

    // Offset-select encodings for addr2_sel.
    typedef enum logic [1:0] {
        OFF_ZERO = 2'd0,
        OFF_A    = 2'd1,
        OFF_B    = 2'd2,
        OFF_C    = 2'd3
    } off_sel_e;

    // Stage 1 registers.
    logic               s1_valid;
    logic [WIDTH-1:0]   s1_base;
    logic [WIDTH-1:0]   s1_off;
    logic               s1_word;
    logic [TAG_W-1:0]   s1_tag;

    // Stage 2 valid; the stage 2 payload lives in the output registers.
    logic               s2_valid;

    // Handshake and datapath nets.
    logic               in_xfer;
    logic               s2_adv;
    logic [WIDTH-1:0]   base_sel;
    logic [WIDTH-1:0]   off_a;
    logic [WIDTH-1:0]   off_b;
    logic [WIDTH-1:0]   off_c;
    logic [WIDTH-1:0]   off_sel;
    logic [WIDTH-1:0]   off_shf;
    logic [WIDTH-1:0]   ea_sum;
    logic               ea_misalign;

    // Stage 2 can take stage 1 when it is empty or is draining this cycle.
    // in_ready depends only on state and out_ready, never on in_valid.
    assign s2_adv   = s1_valid & (~s2_valid | out_ready);
    assign in_ready = ~s1_valid | s2_adv;
    assign in_xfer  = in_valid & in_ready;

    // Sign-extend each field from its own MSB; a sized cast of a signed
    // operand replicates the sign bit up to WIDTH.
    assign off_a = WIDTH'($signed(ir_slice[OFF_A_W-1:0]));
    assign off_b = WIDTH'($signed(ir_slice[OFF_B_W-1:0]));
    assign off_c = WIDTH'($signed(ir_slice[OFF_C_W-1:0]));

    assign base_sel = addr1_sel ? r : pc;

    // Select the offset field for this request.
    always_comb begin
        // NOTE: default first so every path assigns off_sel and no latch is inferred.
        off_sel = '0;
        case (off_sel_e'(addr2_sel))
            OFF_ZERO: off_sel = '0;
            OFF_A:    off_sel = off_a;
            OFF_B:    off_sel = off_b;
            OFF_C:    off_sel = off_c;
            default:  off_sel = '0;
        endcase
    end

    // The bit shifted out of the MSB is dropped.
    assign off_shf = lshf1 ? {off_sel[WIDTH-2:0], 1'b0} : off_sel;

    // Stage 2 arithmetic: modulo-2^WIDTH add, carry discarded.
    assign ea_sum      = s1_base + s1_off;
    assign ea_misalign = ALIGN_CHECK & s1_word & ea_sum[0];

    // Stage 1: capture base, offset, word flag and tag on input transfer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: sequential state uses non-blocking assignments so all
            // registers update together from pre-edge values.
            s1_valid <= 1'b0;
            s1_base  <= '0;
            s1_off   <= '0;
            s1_word  <= 1'b0;
            s1_tag   <= '0;
        end else begin
            if (in_xfer) begin
                s1_valid <= 1'b1;
                s1_base  <= base_sel;
                s1_off   <= off_shf;
                s1_word  <= word;
                s1_tag   <= in_tag;
            end else if (s2_adv) begin
                s1_valid <= 1'b0;
            end
        end
    end

    // Stage 2: load the sum into the output registers or hold under stall.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid     <= 1'b0;
            out_ea       <= '0;
            out_misalign <= 1'b0;
            out_tag      <= '0;
        end else begin
            if (s2_adv) begin
                s2_valid     <= 1'b1;
                out_ea       <= ea_sum;
                out_misalign <= ea_misalign;
                out_tag      <= s1_tag;
            end else if (out_ready) begin
                s2_valid <= 1'b0;
            end
        end
    end

    assign out_valid = s2_valid;

endmodule

// File: tb/tb_eab_pipe.sv
// tb_eab_pipe: directed self-checking bench for eab_pipe. A second instance
// with ALIGN_CHECK=0 shares the stimulus so its misalign output can be checked.
module tb_eab_pipe;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [10:0] ir_slice;
    logic [15:0] r;
    logic [15:0] pc;
    logic        addr1_sel;
    logic [1:0]  addr2_sel;
    logic        lshf1;
    logic        word;
    logic [3:0]  in_tag;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_ea;
    logic        out_misalign;
    logic [3:0]  out_tag;

    logic        nc_in_ready;
    logic        nc_out_valid;
    logic [15:0] nc_out_ea;
    logic        nc_out_misalign;
    logic [3:0]  nc_out_tag;

    int n_compared;
    int n_mismatched;

    eab_pipe dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .ir_slice(ir_slice), .r(r), .pc(pc), .addr1_sel(addr1_sel),
        .addr2_sel(addr2_sel), .lshf1(lshf1), .word(word), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready), .out_ea(out_ea),
        .out_misalign(out_misalign), .out_tag(out_tag)
    );

    eab_pipe #(.ALIGN_CHECK(1'b0)) dut_nc (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(nc_in_ready),
        .ir_slice(ir_slice), .r(r), .pc(pc), .addr1_sel(addr1_sel),
        .addr2_sel(addr2_sel), .lshf1(lshf1), .word(word), .in_tag(in_tag),
        .out_valid(nc_out_valid), .out_ready(out_ready), .out_ea(nc_out_ea),
        .out_misalign(nc_out_misalign), .out_tag(nc_out_tag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_compared++;
        if (got !== exp) begin
            n_mismatched++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Scramble request inputs so a result can only come from sampled values.
    task automatic scramble();
        ir_slice  = 11'h555;
        r         = 16'hDEAD;
        pc        = 16'hBEEF;
        addr1_sel = 1'b0;
        addr2_sel = 2'd3;
        lshf1     = 1'b1;
        word      = 1'b1;
        in_tag    = 4'hF;
    endtask

    // Single request with no backpressure; called #1 after a rising edge.
    task automatic one(input string name, input logic [10:0] ir, input logic [15:0] rv,
                       input logic [15:0] pcv, input logic a1, input logic [1:0] a2,
                       input logic l, input logic w, input logic [3:0] tg,
                       input logic [15:0] exp_ea, input logic exp_mis, input logic exp_mis_nc);
        check({name, "_in_ready"}, 32'(in_ready), 32'd1);
        ir_slice = ir; r = rv; pc = pcv; addr1_sel = a1; addr2_sel = a2;
        lshf1 = l; word = w; in_tag = tg; in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        scramble();
        check({name, "_valid_lat1"}, 32'(out_valid), 32'd0);
        @(posedge clk); #1;
        check({name, "_valid_lat2"}, 32'(out_valid), 32'd1);
        check({name, "_ea"}, 32'(out_ea), 32'(exp_ea));
        check({name, "_mis"}, 32'(out_misalign), 32'(exp_mis));
        check({name, "_mis_nc"}, 32'(nc_out_misalign), 32'(exp_mis_nc));
        check({name, "_tag"}, 32'(out_tag), 32'(tg));
        @(posedge clk); #1;
        check({name, "_drained"}, 32'(out_valid), 32'd0);
    endtask

    initial begin
        n_compared   = 0;
        n_mismatched = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        scramble();

        // Reset state.
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_ea", 32'(out_ea), 32'd0);
        check("rst_out_mis", 32'(out_misalign), 32'd0);
        check("rst_out_tag", 32'(out_tag), 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("rst_in_ready", 32'(in_ready), 32'd1);

        // Field B, -1 shifted: 0x3000 - 2.
        one("basic", 11'h1FF, 16'h0000, 16'h3000, 1'b0, 2'd2, 1'b1, 1'b1, 4'd5, 16'h2FFE, 1'b0, 1'b0);
        // Field A = 5 (upper IR bits ignored), wraps past 0xFFFF.
        one("wrap", 11'h7C5, 16'hFFFE, 16'h0000, 1'b1, 2'd1, 1'b0, 1'b0, 4'd1, 16'h0003, 1'b0, 1'b0);
        // Odd word address.
        one("mis_word", 11'h003, 16'h4000, 16'h0000, 1'b1, 2'd1, 1'b0, 1'b1, 4'd2, 16'h4003, 1'b1, 1'b0);
        one("mis_byte", 11'h003, 16'h4000, 16'h0000, 1'b1, 2'd1, 1'b0, 1'b0, 4'd3, 16'h4003, 1'b0, 1'b0);
        // Zero offset returns the base regardless of IR and shift.
        one("zero_off", 11'h7FF, 16'h1234, 16'h0000, 1'b1, 2'd0, 1'b1, 1'b0, 4'd4, 16'h1234, 1'b0, 1'b0);
        // Field C 0x400 = -1024, shifted -2048, plus 0x1000.
        one("field_c", 11'h400, 16'h0000, 16'h1000, 1'b0, 2'd3, 1'b1, 1'b0, 4'd6, 16'h0800, 1'b0, 1'b0);
        // Field A 0x20 = -32, shifted -64, plus 0x0100.
        one("neg_a", 11'h020, 16'h0100, 16'h0000, 1'b1, 2'd1, 1'b1, 1'b1, 4'd7, 16'h00C0, 1'b0, 1'b0);
        // Field B +255, no shift, odd word address.
        one("pos_b", 11'h0FF, 16'h0000, 16'h3000, 1'b0, 2'd2, 1'b0, 1'b1, 4'd8, 16'h30FF, 1'b1, 1'b0);

        // Backpressure: four requests, base 0x1000+tag, zero offset.
        out_ready = 1'b0;
        addr1_sel = 1'b1; addr2_sel = 2'd0; lshf1 = 1'b0; word = 1'b0;
        in_valid = 1'b1; in_tag = 4'd0; r = 16'h1000;
        check("bp_c0_ready", 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        in_tag = 4'd1; r = 16'h1001;
        check("bp_c1_ready", 32'(in_ready), 32'd1);
        check("bp_c1_valid", 32'(out_valid), 32'd0);
        @(posedge clk); #1;
        in_tag = 4'd2; r = 16'h1002;
        check("bp_c2_ready", 32'(in_ready), 32'd0);
        check("bp_c2_valid", 32'(out_valid), 32'd1);
        check("bp_c2_tag", 32'(out_tag), 32'd0);
        check("bp_c2_ea", 32'(out_ea), 32'h1000);
        @(posedge clk); #1;
        check("bp_c3_ready", 32'(in_ready), 32'd0);
        check("bp_c3_tag_hold", 32'(out_tag), 32'd0);
        check("bp_c3_ea_hold", 32'(out_ea), 32'h1000);
        out_ready = 1'b1;
        #1;
        check("bp_c3_ready_up", 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        in_tag = 4'd3; r = 16'h1003;
        for (int i = 1; i <= 3; i++) begin
            check($sformatf("bp_out%0d_valid", i), 32'(out_valid), 32'd1);
            check($sformatf("bp_out%0d_tag", i), 32'(out_tag), 32'(i));
            check($sformatf("bp_out%0d_ea", i), 32'(out_ea), 32'h1000 + 32'(i));
            if (i == 1) check("bp_out1_ready", 32'(in_ready), 32'd1);
            @(posedge clk); #1;
            in_valid = 1'b0;
        end
        check("bp_empty", 32'(out_valid), 32'd0);

        // Reset mid-flight with both stages full.
        out_ready = 1'b0;
        addr1_sel = 1'b1; addr2_sel = 2'd0;
        in_valid = 1'b1; in_tag = 4'hA; r = 16'h2222;
        @(posedge clk); #1;
        in_tag = 4'hB; r = 16'h3333;
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("mid_pre_valid", 32'(out_valid), 32'd1);
        check("mid_pre_ea", 32'(out_ea), 32'h2222);
        #1 rst_n = 1'b0;
        #1;
        check("mid_rst_valid", 32'(out_valid), 32'd0);
        check("mid_rst_ea", 32'(out_ea), 32'd0);
        check("mid_rst_tag", 32'(out_tag), 32'd0);
        #1 rst_n = 1'b1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        check("mid_post_ready", 32'(in_ready), 32'd1);
        for (int i = 0; i < 3; i++) begin
            check($sformatf("mid_no_stale%0d", i), 32'(out_valid), 32'd0);
            @(posedge clk); #1;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule

// File: doc/eab_pipe.md
Name: eab_pipe

Overview:
Pipelined, parametrised effective-address generator for the LC-3b datapath. It computes base (PC or register) plus a sign-extended IR offset, optionally left-shifted by one. A valid/ready handshake on both sides lets the memory stage stall it without losing requests. It also flags misaligned word accesses and carries a request tag alongside each address.

Parameters:
WIDTH, 16, address/data width; all arithmetic modulo 2^WIDTH
OFF_A_W, 6, width of offset field A (IR[OFF_A_W-1:0])
OFF_B_W, 9, width of offset field B (IR[OFF_B_W-1:0])
OFF_C_W, 11, width of offset field C (IR[OFF_C_W-1:0]); also the ir_slice width; must satisfy OFF_A_W <= OFF_B_W <= OFF_C_W <= WIDTH
TAG_W, 4, width of the opaque request tag
ALIGN_CHECK, 1, 1 = compute out_misalign; 0 = tie out_misalign to 0

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  request present
in_ready  output  1  block can accept the request this cycle
ir_slice  input  OFF_C_W  raw IR offset bits
r  input  WIDTH  base register value
pc  input  WIDTH  incremented PC
addr1_sel  input  1  base select: 1 = r, 0 = pc
addr2_sel  input  2  offset select: 0 = zero, 1 = field A, 2 = field B, 3 = field C
lshf1  input  1  shift the selected offset left by 1
word  input  1  access is a word access (alignment-checked)
in_tag  input  TAG_W  request tag
out_valid  output  1  result present
out_ready  input  1  consumer accepts the result this cycle
out_ea  output  WIDTH  effective address
out_misalign  output  1  word access with out_ea[0] = 1
out_tag  output  TAG_W  tag of this result

Behaviour:
- Reset (rst_n low, asynchronous): s1_valid = 0, s2_valid = 0, out_ea = 0, out_misalign = 0, out_tag = 0, and all stage registers = 0. in_ready = 1 in the first cycle after reset release.
- Transfer rules: input transfer when in_valid & in_ready; output transfer when out_valid & out_ready.
- Stage 1 (capture): register the following on input transfer:
  - base = addr1_sel ? r : pc
  - off = offset per addr2_sel, sign-extended to WIDTH from the field MSB (IR[OFF_x_W-1]), then shifted left by lshf1; the bit shifted out of bit WIDTH-1 is discarded
  - word and tag
- Stage 2 (add): ea = (base + off) mod 2^WIDTH, carry discarded. misalign = ALIGN_CHECK & word & ea[0]. ea, misalign and tag are registered into the output registers.
- Outputs: out_valid = s2_valid, and out_ea, out_misalign, out_tag are driven directly from registers.
- Flow control: each stage advances when the downstream stage is empty or is transferring in the same cycle.
  - s2_adv = s1_valid & (!s2_valid | out_ready)
  - in_ready = !s1_valid | s2_adv (combinational; no combinational path from in_valid to in_ready)
- Latency: exactly 2 cycles from input transfer to out_valid with no backpressure. Throughput is 1 per cycle.
- Stall: with out_valid = 1 and out_ready = 0, out_ea, out_misalign and out_tag hold stable. Stage 1 keeps its content. in_ready falls once both stages are full (at most 2 requests in flight).
- Simultaneous events: an output transfer, a stage-2 load and an input transfer in the same cycle are all legal. There is no bubble and no duplication.
- Request fields are sampled only on transfer cycles; inputs are don't-care when in_valid = 0.
- Reset mid-operation drops all in-flight requests; out_valid goes low immediately.
- Order is preserved: results leave in the same order as requests were accepted.

Test Plan:
- Basic offset: pc=0x3000, addr1_sel=0, addr2_sel=2, ir_slice[8:0]=0x1FF (-1), lshf1=1, word=1, tag=5 -> out_valid exactly 2 cycles later, out_ea=0x2FFE, out_misalign=0, out_tag=5.
- Wrap-around: r=0xFFFE, addr1_sel=1, addr2_sel=1, ir_slice[5:0]=0x05, lshf1=0, word=0 -> out_ea=0x0003, out_misalign=0.
- Misalign: r=0x4000, addr2_sel=1, offset 0x03, lshf1=0, word=1 -> out_ea=0x4003, out_misalign=1. Same request with word=0 -> out_misalign=0. With ALIGN_CHECK=0 -> out_misalign=0.
- Backpressure: send 4 back-to-back requests (tags 0..3) with out_ready=0 -> in_ready drops after 2 accepted, out_ea/out_tag stable (tag 0). Then raise out_ready -> tags 0,1,2,3 emerge in order, one per cycle, none lost or duplicated.
- Zero offset and field C: addr2_sel=0 -> out_ea=base. addr2_sel=3, ir_slice=0x400, lshf1=1, pc=0x1000 -> out_ea=0x0800.
- Reset mid-flight: 2 requests in flight, pulse rst_n low between clock edges -> out_valid=0 and out_ea=0 immediately; after release in_ready=1 and no stale result appears.
